mem_port_arbiter: RTL

//  Shares one external memory port between the core's instruction bus and data bus.

---
 rtl/memarb_pkg.sv | 33 +++
 rtl/memarb_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/memarb_pkg.sv
// Shared types for the memory port arbiter: FSM states, latched request bundle,
// widths, the instruction fetch size code and the fetch word selector.
package memarb_pkg;

  localparam int unsigned MA_ADDR_W = 64;
  localparam int unsigned MA_DATA_W = 64;

  // Size codes: 0 byte, 1 half, 2 word, 3 dword
  localparam logic [2:0] MSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } memarb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MA_ADDR_W-1:0] addr;
    logic [2:0]           size;
    logic [7:0]           strobe;
    logic [MA_DATA_W-1:0] wdata;
  } mbus_req_t;

  // Fetch data is the 32-bit half of the memory word picked by addr[2]
  function automatic logic [31:0] word_sel(
    input logic [MA_DATA_W-1:0] d,
    input logic                 hi
  );
    return hi ? d[63:32] : d[31:0];
  endfunction

endpackage

// File: rtl/memarb_pick.sv
// Grant picker for the memory port arbiter.
// Ports: i_fetch_vld, i_data_vld, i_last_d (1 = D granted last) -> o_grant_i, o_grant_d.
// Build option: MEMARB_RR_EN selects round-robin on ties, otherwise D wins ties.
module memarb_pick (
  input  logic i_fetch_vld,
  input  logic i_data_vld,
  input  logic i_last_d,
  output logic o_grant_i,
  output logic o_grant_d
);

`ifdef MEMARB_RR_EN
  // On a tie the side that did not win last time goes first
  assign o_grant_d = i_data_vld & (~i_fetch_vld | ~i_last_d);
`else
  logic w_unused_last;
  assign w_unused_last = i_last_d;
  assign o_grant_d     = i_data_vld;
`endif

  assign o_grant_i = i_fetch_vld & ~o_grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction and data buses; one grant at a time.
// Ports: clk, reset (sync, high); i_* fetch bus; d_* data bus; m_* memory port.
// Build option: MEMARB_RR_EN enables round-robin tie breaking (default D over I).
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned ADDR_W = MA_ADDR_W,
  parameter int unsigned DATA_W = MA_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_data_ok,
  output logic [31:0]       i_data,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [7:0]        d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_size,
  output logic [7:0]        m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  memarb_state_e r_state;
  mbus_req_t     r_req;
  logic          w_last_d;
  logic          w_grant_i;
  logic          w_grant_d;

`ifdef MEMARB_RR_EN
  logic r_last_d;
  assign w_last_d = r_last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_grant_d) begin
        r_last_d <= 1'b1;
      end else if (w_grant_i) begin
        r_last_d <= 1'b0;
      end
    end
  end
`else
  assign w_last_d = 1'b0;
`endif

  memarb_pick u_pick (
    .i_fetch_vld (i_valid),
    .i_data_vld  (d_valid),
    .i_last_d    (w_last_d),
    .o_grant_i   (w_grant_i),
    .o_grant_d   (w_grant_d)
  );

  // The request is latched at grant so the memory sees stable fields
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state      <= SERVE_D;
            r_req.valid  <= 1'b1;
            r_req.addr   <= d_addr;
            r_req.size   <= d_size;
            r_req.strobe <= d_strobe;
            r_req.wdata  <= d_wdata;
          end else if (w_grant_i) begin
            r_state      <= SERVE_I;
            r_req.valid  <= 1'b1;
            r_req.addr   <= i_addr;
            r_req.size   <= MSIZE_WORD;
            r_req.strobe <= 8'h00;
            r_req.wdata  <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (m_data_ok) begin
            r_state <= IDLE;
            r_req   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= '0;
        end
      endcase
    end
  end

  assign m_valid  = r_req.valid;
  assign m_addr   = r_req.addr;
  assign m_size   = r_req.size;
  assign m_strobe = r_req.strobe;
  assign m_wdata  = r_req.wdata;

  // Responses go straight through to the winner in the m_data_ok cycle
  assign i_data_ok = (r_state == SERVE_I) & m_data_ok;
  assign d_data_ok = (r_state == SERVE_D) & m_data_ok;

  assign i_data  = i_data_ok ? word_sel(m_rdata, r_req.addr[2]) : 32'h0;
  assign d_rdata = d_data_ok ? m_rdata : '0;

endmodule
